// File: rtl/bus_arbiter_rr.sv
// Round-robin owner register for four active-low bus masters with registered, parked grants.
// Optional tenure preemption is compiled in with `define ARB_PREEMPT_EN.
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       bus_as_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner
);

  // Handshake: a master asserts req_ low and owns the bus from the edge after which its
  // grnt_ reads low; it keeps it while req_ stays low and gives it up by raising req_.
  typedef enum logic {
    ST_HOLD    = 1'b0,
    ST_RELEASE = 1'b1
  } state_t;

  state_t     w_state;
  logic [3:0] w_req;
  logic [1:0] r_owner;
  logic [3:0] r_grnt_n;
  logic [1:0] w_owner_nxt;
  logic       w_found;
  logic [1:0] w_cand;
  logic       w_preempt;

  assign w_req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // First requester after the owner, wrapping modulo 4; the owner itself is never a candidate.
  always_comb begin : search
    logic [1:0] idx;
    w_found = 1'b0;
    w_cand  = r_owner;
    idx     = r_owner;
    for (int k = 1; k < 4; k++) begin
      idx = r_owner + 2'(k);
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_cand  = idx;
      end
    end
  end

`ifdef ARB_PREEMPT_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] r_cnt;

  assign w_preempt = (r_cnt >= HOLD_LIM) && bus_as_;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_owner_nxt != r_owner) begin
      r_cnt <= '0;
    end else if (w_state == ST_HOLD && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_preempt = 1'b0;
  assign w_unused  = bus_as_ & (MAX_HOLD != 0) & (CNT_W != 0);
`endif

  always_comb begin : next_state
    w_state     = w_req[r_owner] ? ST_HOLD : ST_RELEASE;
    w_owner_nxt = r_owner;
    case (w_state)
      ST_HOLD:    if (w_preempt && w_found) w_owner_nxt = w_cand;
      ST_RELEASE: if (w_found) w_owner_nxt = w_cand;
      default:    w_owner_nxt = r_owner;
    endcase
  end

  // Grants are decoded from the next owner so they change on the same edge as owner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner  <= 2'd0;
      r_grnt_n <= 4'b1110;
    end else begin
      r_owner  <= w_owner_nxt;
      r_grnt_n <= ~(4'b0001 << w_owner_nxt);
    end
  end

  assign owner    = r_owner;
  assign m0_grnt_ = r_grnt_n[0];
  assign m1_grnt_ = r_grnt_n[1];
  assign m2_grnt_ = r_grnt_n[2];
  assign m3_grnt_ = r_grnt_n[3];

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed vector table, hand sequences for multi-cycle cases,
// then random traffic checked against a rule-level model of the arbiter.
module tb_bus_arbiter_rr;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic       clk;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       bus_as_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;

  int n_checks;
  int n_fail;

  int m_owner;
`ifdef ARB_PREEMPT_EN
  int m_cnt;
`endif

  typedef struct {
    logic       rst_n;
    logic [3:0] req_n;
    logic       as_n;
    logic [1:0] exp_owner;
  } vec_t;

  vec_t tbl[18];

  bus_arbiter_rr #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (m0_req_),
    .m1_req_  (m1_req_),
    .m2_req_  (m2_req_),
    .m3_req_  (m3_req_),
    .bus_as_  (bus_as_),
    .m0_grnt_ (m0_grnt_),
    .m1_grnt_ (m1_grnt_),
    .m2_grnt_ (m2_grnt_),
    .m3_grnt_ (m3_grnt_),
    .owner    (owner)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: reset forces m0; a released bus goes to the first requester in
  // the order owner+1, owner+2, owner+3 (mod 4); a held bus changes only by preemption.
  task automatic model_update(input logic rst_n, input logic [3:0] req_n, input logic as_n);
    int cand;
    cand = -1;
    if (!rst_n) begin
      m_owner = 0;
`ifdef ARB_PREEMPT_EN
      m_cnt = 0;
`endif
    end else begin
      for (int k = 1; k < 4; k++) begin
        if (cand < 0 && req_n[(m_owner + k) % 4] == 1'b0) cand = (m_owner + k) % 4;
      end
      if (req_n[m_owner] == 1'b1) begin
        if (cand >= 0) begin
          m_owner = cand;
`ifdef ARB_PREEMPT_EN
          m_cnt = 0;
`endif
        end
      end else begin
`ifdef ARB_PREEMPT_EN
        if (m_cnt >= MAX_HOLD && cand >= 0 && as_n == 1'b1) begin
          m_owner = cand;
          m_cnt   = 0;
        end else if (m_cnt < CNT_MAX) begin
          m_cnt = m_cnt + 1;
        end
`else
        if (as_n === 1'bx) m_owner = m_owner;
`endif
      end
    end
  endtask

  function automatic logic [3:0] grants();
    return {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
  endfunction

  task automatic check(input string name, input int exp_owner);
    logic [3:0] exp_g;
    exp_g = ~(4'b0001 << exp_owner);
    n_checks++;
    if (owner !== 2'(exp_owner) || grants() !== exp_g) begin
      n_fail++;
      $display("FAIL %s: owner=%0d grnt_=%b, expected owner=%0d grnt_=%b",
               name, owner, grants(), exp_owner, exp_g);
    end
  endtask

  task automatic check_onehot();
    n_checks++;
    if (!$onehot(~grants())) begin
      n_fail++;
      $display("FAIL grant_onehot: grnt_=%b, expected exactly one low", grants());
    end
  endtask

  // Driver: inputs change at negedge, model steps at posedge, outputs sampled #1 later.
  task automatic step(input logic rst_n, input logic [3:0] req_n, input logic as_n);
    @(negedge clk);
    reset   = rst_n;
    {m3_req_, m2_req_, m1_req_, m0_req_} = req_n;
    bus_as_ = as_n;
    @(posedge clk);
    model_update(rst_n, req_n, as_n);
    #1;
    check_onehot();
  endtask

  initial begin
    int exp_o;
    logic [3:0] rq;
    logic       rs;
    logic       as;

    n_checks = 0;
    n_fail   = 0;
    m_owner  = 0;
`ifdef ARB_PREEMPT_EN
    m_cnt    = 0;
`endif
    reset = 1'b0;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;
    bus_as_ = 1'b1;

    // bus_as_ held low in the table so preemption cannot interfere with hand expectations
    tbl[0]  = '{1'b0, 4'b1111, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b0, 2'd0};
    tbl[3]  = '{1'b1, 4'b1011, 1'b0, 2'd2};
    tbl[4]  = '{1'b1, 4'b1011, 1'b0, 2'd2};
    tbl[5]  = '{1'b1, 4'b1111, 1'b0, 2'd2};
    tbl[6]  = '{1'b1, 4'b1011, 1'b0, 2'd2};
    tbl[7]  = '{1'b1, 4'b0111, 1'b0, 2'd3};
    tbl[8]  = '{1'b1, 4'b0111, 1'b0, 2'd3};
    tbl[9]  = '{1'b1, 4'b1001, 1'b0, 2'd1};
    tbl[10] = '{1'b1, 4'b1001, 1'b0, 2'd1};
    tbl[11] = '{1'b1, 4'b1011, 1'b0, 2'd2};
    tbl[12] = '{1'b0, 4'b1011, 1'b0, 2'd0};
    tbl[13] = '{1'b1, 4'b1010, 1'b0, 2'd0};
    tbl[14] = '{1'b1, 4'b1011, 1'b0, 2'd2};
    tbl[15] = '{1'b1, 4'b0111, 1'b0, 2'd3};
    tbl[16] = '{1'b1, 4'b1010, 1'b0, 2'd0};
    tbl[17] = '{1'b1, 4'b1111, 1'b0, 2'd0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst_n, tbl[i].req_n, tbl[i].as_n);
      check($sformatf("vec%0d", i), int'(tbl[i].exp_owner));
    end

    // All four requesting: 3-cycle tenures with a 1-cycle release rotate 0,1,2,3,0
    step(1'b0, 4'b0000, 1'b0);
    check("rr_reset", 0);
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 3; t++) begin
        step(1'b1, 4'b0000, 1'b0);
        check($sformatf("rr_hold_r%0d_t%0d", r, t), r % 4);
      end
      step(1'b1, 4'b0001 << (r % 4), 1'b0);
      check($sformatf("rr_handover_r%0d", r), (r + 1) % 4);
    end

    // Long tenure by m1 with m3 waiting; access in flight blocks any preemption
    step(1'b0, 4'b1111, 1'b1);
    check("pre_reset", 0);
    step(1'b1, 4'b1101, 1'b0);
    check("pre_grant_m1", 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'b0101, 1'b0);
      check($sformatf("pre_as_low%0d", i), 1);
    end
`ifdef ARB_PREEMPT_EN
    exp_o = 3;
`else
    exp_o = 1;
`endif
    step(1'b1, 4'b0101, 1'b1);
    check("pre_as_rise", exp_o);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0101, 1'b1);
      check($sformatf("pre_after%0d", i), exp_o);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b0101, 1'b1);
      check($sformatf("pre_long%0d", i), m_owner);
    end

    // Random traffic; requests drift one bit at a time so tenures last several cycles
    rq = 4'b1111;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, 3)] ^= 1'b1;
      rs = ($urandom_range(0, 39) != 0);
      as = 1'($urandom_range(0, 1));
      step(rs, rq, as);
      check($sformatf("rand%0d", i), m_owner);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
